// File: rtl/fft_helpers_twiddle_stream.sv
`default_nettype none
// ============================================================================
// Module      : fft_helpers_twiddle_stream
// Description : Streaming sine/cosine sample generator. A quarter-wave table
//               of sin(2*pi*i/N), i in [0, N/4], is built at elaboration.
//               Each accepted request emits a burst of cfg_len samples,
//               starting at cfg_phase and advancing by cfg_step (mod N).
//               The samples go out over a val/rdy stream.
// Ports       : clk, reset                - clock, synchronous active-high reset
//               cfg_val/cfg_rdy           - burst request handshake (ready in IDLE)
//               cfg_phase/cfg_step/cfg_len- start phase, phase step, burst length
//               send_val/send_rdy         - sample handshake
//               send_sin/send_cos         - signed Q(W-D).D sine / cosine
//               send_idx/send_last        - phase index, final-sample flag
// Config      : FFT_HELPERS_TWIDDLE_STREAM_COS_EN - when defined, send_cos
//               carries cos(2*pi*idx/N); otherwise send_cos is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_helpers_twiddle_stream #(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int D    = 16,
  parameter int LENW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_val,
  output logic                 cfg_rdy,
  input  logic [$clog2(N)-1:0] cfg_phase,
  input  logic [$clog2(N)-1:0] cfg_step,
  input  logic [LENW-1:0]      cfg_len,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [W-1:0]         send_sin,
  output logic [W-1:0]         send_cos,
  output logic [$clog2(N)-1:0] send_idx,
  output logic                 send_last
);

  localparam int  PW = $clog2(N);
  localparam int  QN = N / 4;
  localparam int  IW = (QN > 0) ? $clog2(QN + 1) : 1;
  localparam real PI = 3.14159265358979323846;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_chk_n
    $error("fft_helpers_twiddle_stream: N must be a power of 2 and >= 4");
  end
  if (D >= 31) begin : g_chk_d
    $error("fft_helpers_twiddle_stream: D must be < 31");
  end
  if (W < D + 2) begin : g_chk_w
    $error("fft_helpers_twiddle_stream: W must be >= D+2");
  end

  // --------------------------------------------------------------------------
  // Quarter-wave table, round-half-away-from-zero. The N/4 entry is forced to
  // exactly 1.0 so the peak never depends on floating-point rounding.
  // --------------------------------------------------------------------------
  logic [W-1:0] tab [0:QN];

  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam real S  = $sin(2.0 * PI * real'(g) / real'(N));
    localparam real SC = S * real'(1 << D);
    localparam int  TV = (g == QN) ? (1 << D)
                                   : $rtoi((SC >= 0.0) ? (SC + 0.5) : (SC - 0.5));
    assign tab[g] = W'(TV);
  end

  // Quadrant folding: q0 T[r], q1 T[N/4-r], q2 -T[r], q3 -T[N/4-r]
  function automatic logic [W-1:0] lookup(input logic [PW-1:0] p);
    logic [1:0]    q;
    logic [IW-1:0] r;
    logic [W-1:0]  v;
    q = 2'(p >> (PW - 2));
    r = IW'(p % PW'(QN));
    case (q)
      2'd0:    v = tab[r];
      2'd1:    v = tab[IW'(QN) - r];
      2'd2:    v = -tab[r];
      default: v = -tab[IW'(QN) - r];
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   phase;
  logic [PW-1:0]   step;
  logic [LENW-1:0] remaining;

  logic cfg_go;   // non-empty request accepted this cycle
  logic adv;      // sample accepted with more samples still to come

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      step      <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      if (cfg_go) begin
        phase     <= cfg_phase;
        step      <= cfg_step;
        remaining <= cfg_len;
      end else if (adv) begin
        phase     <= phase + step;   // wraps naturally mod N
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cfg_rdy   = 1'b0;
    send_val  = 1'b0;
    send_last = 1'b0;
    cfg_go    = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        cfg_rdy = 1'b1;
        // A zero-length request completes the handshake and is dropped.
        if (cfg_val && (cfg_len != '0)) begin
          cfg_go   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        send_val  = 1'b1;
        send_last = (remaining == LENW'(1));
        if (send_rdy) begin
          if (send_last) state_nx = IDLE;
          else           adv      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset masks the handshake outputs and blocks any register update.
    if (reset) begin
      cfg_rdy   = 1'b0;
      send_val  = 1'b0;
      send_last = 1'b0;
      cfg_go    = 1'b0;
      adv       = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sample outputs: purely a function of the phase register.
  // --------------------------------------------------------------------------
  assign send_idx = reset ? '0 : phase;
  assign send_sin = reset ? '0 : lookup(phase);

`ifdef FFT_HELPERS_TWIDDLE_STREAM_COS_EN
  // cos(p) = sin(p + N/4); the add wraps mod N in PW bits.
  assign send_cos = reset ? '0 : lookup(phase + PW'(QN));
`else
  assign send_cos = '0;
`endif

endmodule
`default_nettype wire
